// File: rtl/nios_security_secure_ram.sv
// Avalon-MM secure on-chip RAM slave: byte-lane writes, 1/2-cycle pipelined
// reads with readdatavalid, a lockable write-protected window and a
// hardware zeroize engine that wipes one word per enabled cycle.
module nios_security_secure_ram #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 11,
   parameter int DEPTH        = 1250,
   parameter int READ_LATENCY = 1,
   parameter int PROT_BASE    = 0,
   parameter int PROT_LIMIT   = 127,
   parameter     INIT_FILE    = ""
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_reset_req,
   input  logic                    i_clken,
   input  logic                    i_chipselect,
   input  logic                    i_read,
   input  logic                    i_write,
   input  logic [ADDR_WIDTH-1:0]   i_address,
   input  logic [DATA_WIDTH/8-1:0] i_byteenable,
   input  logic [DATA_WIDTH-1:0]   i_writedata,
   output logic                    o_waitrequest,
   output logic [DATA_WIDTH-1:0]   o_readdata,
   output logic                    o_readdatavalid,
   input  logic                    i_lock,
   input  logic                    i_zeroize,
   output logic                    o_zeroize_busy,
   output logic                    o_wr_violation,
   output logic                    o_addr_error
);
   localparam int NB = DATA_WIDTH/8;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   PBASE_W = (ADDR_WIDTH+1)'(PROT_BASE);
   localparam logic [ADDR_WIDTH:0]   PSPAN_W = (ADDR_WIDTH+1)'(PROT_LIMIT - PROT_BASE);
   localparam logic [ADDR_WIDTH-1:0] LAST_W  = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {IDLE, ZERO} state_t;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_zer_q;
   logic                  r_ae, r_wv;
   logic                  r_rdv;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  w_busy, w_zero_we, w_wait, w_acc, w_zstart;
   logic                  w_in_range, w_in_win, w_viol, w_wr_en, w_rd_acc;
   logic [ADDR_WIDTH:0]   w_off;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic                  w_s_vld;
   logic [DATA_WIDTH-1:0] w_s_dat;

   assign w_wait     = w_busy | i_reset_req;
   assign w_acc      = i_chipselect & (i_read | i_write) & ~w_wait & i_clken;
   assign w_in_range = {1'b0, i_address} < DEPTH_W;
   // Offset compare: addresses below the base wrap to a large value
   assign w_off      = {1'b0, i_address} - PBASE_W;
   assign w_in_win   = w_off <= PSPAN_W;
   assign w_viol     = w_acc & i_write & w_in_range & i_lock & w_in_win;
   assign w_wr_en    = w_acc & i_write & w_in_range & ~(i_lock & w_in_win);
   // read+write together counts as a write only
   assign w_rd_acc   = w_acc & i_read & ~i_write;
   assign w_rd_word  = w_in_range ? r_mem[i_address] : '0;
   assign w_zstart   = i_clken & i_zeroize & ~r_zer_q;

   // Wipe FSM state register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // Wipe FSM next state: start on zeroize edge, leave after the last word
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_zstart) w_next = ZERO;
         ZERO:    if (i_clken && (r_cnt == LAST_W)) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Wipe FSM outputs
   always_comb begin
      w_busy    = (r_state == ZERO);
      w_zero_we = (r_state == ZERO) & i_clken;
   end

   // Wipe address counter; wraps to 0 so each wipe starts at word 0
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)        r_cnt <= '0;
      else if (w_zero_we) r_cnt <= (r_cnt == LAST_W) ? '0 : r_cnt + 1'b1;
   end

   // Zeroize edge detector, sampled only on enabled cycles
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)      r_zer_q <= 1'b0;
      else if (i_clken) r_zer_q <= i_zeroize;
   end

   // RAM array: wipe writes take the port while busy (no accepts then)
   always_ff @(posedge i_clk) begin
      if (w_zero_we) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_en) begin
         for (int b = 0; b < NB; b++)
            if (i_byteenable[b]) r_mem[i_address][b*8 +: 8] <= i_writedata[b*8 +: 8];
      end
   end

   // Error pulses registered at the accept edge, frozen with clken
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ae <= 1'b0;
         r_wv <= 1'b0;
      end else if (i_clken) begin
         r_ae <= w_acc & ~w_in_range;
         r_wv <= w_viol;
      end
   end

   // Extra read stage for the 2-cycle configuration
   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  r_p_vld;
         logic [DATA_WIDTH-1:0] r_p_dat;
         // Intermediate read stage, frozen with clken
         always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
               r_p_vld <= 1'b0;
               r_p_dat <= '0;
            end else if (i_clken) begin
               r_p_vld <= w_rd_acc;
               r_p_dat <= w_rd_word;
            end
         end
         assign w_s_vld = r_p_vld;
         assign w_s_dat = r_p_dat;
      end else begin : g_lat1
         assign w_s_vld = w_rd_acc;
         assign w_s_dat = w_rd_word;
      end
   endgenerate

   // Output stage: readdata only changes when a new word is delivered
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rdv   <= 1'b0;
         r_rdata <= '0;
      end else if (i_clken) begin
         r_rdv <= w_s_vld;
         if (w_s_vld) r_rdata <= w_s_dat;
      end
   end

   assign o_waitrequest   = w_wait;
   assign o_zeroize_busy  = w_busy;
   assign o_readdata      = r_rdata;
   assign o_readdatavalid = r_rdv & i_clken;
   assign o_addr_error    = r_ae & i_clken;
   assign o_wr_violation  = r_wv & i_clken;
endmodule

// File: tb/tb_nios_security_secure_ram.sv
// Scoreboard bench: latency-1 and latency-2 instances share all stimulus;
// a word-array reference model predicts read data, pulses and wipe timing.
module tb_nios_security_secure_ram;
   localparam int DW = 64, AW = 11, DEPTH = 1250, NB = 8, QN = 8192;
   localparam int PB = 0, PL = 127;

   logic clk = 1'b0;
   logic rst, rq, ce, cs, rd, wr, lk, zr;
   logic [AW-1:0] addr;
   logic [NB-1:0] be;
   logic [DW-1:0] wd;
   logic wait1, rdv1, busy1, wv1, ae1;
   logic wait2, rdv2, busy2, wv2, ae2;
   logic [DW-1:0] rdat1, rdat2;

   always #5 clk = ~clk;

   nios_security_secure_ram #(.READ_LATENCY(1)) u_lat1 (
      .i_clk(clk), .i_reset(rst), .i_reset_req(rq), .i_clken(ce),
      .i_chipselect(cs), .i_read(rd), .i_write(wr), .i_address(addr),
      .i_byteenable(be), .i_writedata(wd), .o_waitrequest(wait1),
      .o_readdata(rdat1), .o_readdatavalid(rdv1), .i_lock(lk),
      .i_zeroize(zr), .o_zeroize_busy(busy1), .o_wr_violation(wv1),
      .o_addr_error(ae1));

   nios_security_secure_ram #(.READ_LATENCY(2)) u_lat2 (
      .i_clk(clk), .i_reset(rst), .i_reset_req(rq), .i_clken(ce),
      .i_chipselect(cs), .i_read(rd), .i_write(wr), .i_address(addr),
      .i_byteenable(be), .i_writedata(wd), .o_waitrequest(wait2),
      .o_readdata(rdat2), .o_readdatavalid(rdv2), .i_lock(lk),
      .i_zeroize(zr), .o_zeroize_busy(busy2), .o_wr_violation(wv2),
      .o_addr_error(ae2));

   // reference model state
   logic [DW-1:0] m_mem [DEPTH];
   int            m_left = 0;
   int            ecnt = 0;
   logic          m_zp = 1'b0, p_ae = 1'b0, p_wv = 1'b0, exp_wait = 1'b0;
   // expected-read scoreboard, one tail shared, one head per instance
   logic [DW-1:0] e_dat [QN];
   int            e_stp [QN];
   int            t = 0;
   int            h [2] = '{0, 0};
   int            tot = 0, bad = 0;

   task automatic chk(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
      tot++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, a, e, $time);
      end
   endtask

   task automatic mon(input int k, input logic v, input logic [DW-1:0] d);
      int lat, idx, age;
      lat = k + 1;
      idx = h[k] % QN;
      age = (h[k] != t) ? ecnt - e_stp[idx] : -1;
      if (v) begin
         if (!ce)           chk($sformatf("rdv_frozen%0d", lat), DW'(v), 0);
         else if (h[k] == t) chk($sformatf("rdv_unexpected%0d", lat), DW'(v), 0);
         else begin
            chk($sformatf("rdata%0d", lat), d, e_dat[idx]);
            chk($sformatf("rd_latency%0d", lat), DW'(age), DW'(lat));
            h[k]++;
         end
      end else if (ce && h[k] != t && age >= lat) begin
         chk($sformatf("rdv_missing%0d", lat), DW'(v), 1);
         h[k]++;
      end
   endtask

   // monitor: every cycle, away from the active edge
   always @(negedge clk) begin
      chk("wait1", DW'(wait1), DW'(exp_wait));
      chk("wait2", DW'(wait2), DW'(exp_wait));
      chk("busy1", DW'(busy1), DW'(m_left > 0));
      chk("busy2", DW'(busy2), DW'(m_left > 0));
      chk("addr_err1", DW'(ae1), DW'(p_ae & ce));
      chk("addr_err2", DW'(ae2), DW'(p_ae & ce));
      chk("wr_viol1", DW'(wv1), DW'(p_wv & ce));
      chk("wr_viol2", DW'(wv2), DW'(p_wv & ce));
      mon(0, rdv1, rdat1);
      mon(1, rdv2, rdat2);
   end

   // one bus cycle: drive, predict, let the edge pass, update the model
   task automatic cyc(input logic c_cs, c_rd, c_wr, input logic [AW-1:0] a,
                      input logic [NB-1:0] b, input logic [DW-1:0] d,
                      input logic c_lk, c_zr, c_ce, c_rq);
      logic acc, inr, wv;
      cs = c_cs; rd = c_rd; wr = c_wr; addr = a; be = b; wd = d;
      lk = c_lk; zr = c_zr; ce = c_ce; rq = c_rq;
      exp_wait = (m_left > 0) | c_rq;
      acc = c_cs & (c_rd | c_wr) & ~exp_wait & c_ce;
      inr = int'(a) < DEPTH;
      wv  = acc & c_wr & inr & c_lk & (int'(a) >= PB) & (int'(a) <= PL);
      if (acc & c_rd & ~c_wr) begin
         e_dat[t % QN] = inr ? m_mem[a] : '0;
         e_stp[t % QN] = ecnt;
         t++;
      end
      @(posedge clk); #1;
      if (c_ce) begin
         ecnt++;
         if (acc & c_wr & inr & ~wv)
            for (int i = 0; i < NB; i++)
               if (b[i]) m_mem[a][i*8 +: 8] = d[i*8 +: 8];
         if (m_left > 0) begin
            m_mem[DEPTH - m_left] = '0;
            m_left--;
         end else if (c_zr & ~m_zp) begin
            m_left = DEPTH;
         end
         m_zp = c_zr;
         p_ae = acc & ~inr;
         p_wv = wv;
      end
   endtask

   task automatic rd_(input int a);
      cyc(1, 1, 0, AW'(a), '0, '0, lk, 0, 1, 0);
   endtask
   task automatic wr_(input int a, input logic [NB-1:0] b, input logic [DW-1:0] d, input logic l);
      cyc(1, 0, 1, AW'(a), b, d, l, 0, 1, 0);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, '0, lk, 0, 1, 0);
   endtask

   task automatic do_reset();
      rst = 1; cs = 0; rd = 0; wr = 0; zr = 0; rq = 0; ce = 1; lk = 0;
      addr = '0; be = '0; wd = '0;
      m_left = 0; p_ae = 0; p_wv = 0; m_zp = 0; exp_wait = 0;
      h[0] = t; h[1] = t;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 0;
   endtask

   function automatic logic [AW-1:0] raddr();
      case ($urandom_range(0, 3))
         0:       return AW'($urandom_range(0, 15));
         1:       return AW'($urandom_range(120, 135));
         2:       return AW'($urandom_range(1244, 1255));
         default: return AW'($urandom_range(0, 2047));
      endcase
   endfunction

   initial begin
      int nb;
      int op;
      do_reset();
      chk("rst_rdata1", rdat1, 0);
      chk("rst_rdata2", rdat2, 0);
      chk("rst_rdv1", DW'(rdv1), 0);
      chk("rst_rdv2", DW'(rdv2), 0);
      chk("rst_busy", DW'(busy1), 0);

      // full wipe with a second zeroize edge mid-way and blocked reads
      cyc(0, 0, 0, '0, '0, '0, 0, 1, 1, 0);
      nb = 0;
      for (int i = 0; i < 1300; i++) begin
         if (busy1) nb++;
         cyc(1, 1, 0, raddr(), '0, '0, 0, (i < 100) || (i >= 200 && i < 300), 1, 0);
      end
      chk("wipe_cycles", DW'(nb), DW'(DEPTH));
      for (int a = 0; a <= DEPTH; a++) rd_(a);

      // byte-lane writes and reads, back-to-back
      lk = 0;
      wr_(5, 8'hFF, 64'h0123_4567_89AB_CDEF, 0);
      rd_(5);
      idle(2);
      wr_(5, 8'h0F, {DW{1'b1}}, 0);
      rd_(5); rd_(6); rd_(1250); rd_(0);
      idle(3);

      // locked window, then unlocked
      wr_(10, 8'hFF, 64'h1111_2222_3333_4444, 0);
      wr_(10, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD, 1);
      lk = 1; rd_(10);
      wr_(200, 8'hFF, 64'h5555_6666_7777_8888, 1);
      rd_(200);
      lk = 0;
      wr_(10, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD, 0);
      rd_(10);

      // out-of-range accesses
      rd_(1250);
      wr_(2000, 8'hFF, 64'hFFFF_0000_FFFF_0000, 0);
      rd_(2000);
      cyc(1, 1, 1, AW'(7), 8'hFF, 64'h7777, 0, 0, 1, 0);
      rd_(7);
      idle(2);

      // clken freeze mid-read and reset_req stall
      rd_(5);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, '0, '0, 0, 0, 0, 0);
      idle(3);
      rd_(6);
      cyc(1, 1, 0, AW'(5), '0, '0, 0, 0, 1, 1);
      cyc(1, 1, 0, AW'(5), '0, '0, 0, 0, 1, 1);
      idle(3);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         op = $urandom_range(0, 9);
         cyc($urandom_range(0, 9) != 0, (op < 5) || (op == 9), op >= 5, raddr(),
             NB'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0,
             $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0);
      end
      idle(3);

      // reset partway through a wipe
      wr_(0, 8'hFF, 64'h0BAD_F00D_0000_0001, 0);
      wr_(600, 8'hFF, 64'h0BAD_F00D_0000_0600, 0);
      wr_(1000, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 0);
      rd_(0);
      cyc(0, 0, 0, '0, '0, '0, 0, 1, 1, 0);
      for (int i = 0; i < 700 && m_left > DEPTH - 600; i++)
         cyc(0, 0, 0, '0, '0, '0, 0, 1, 1, 0);
      do_reset();
      chk("mid_rst_busy1", DW'(busy1), 0);
      chk("mid_rst_busy2", DW'(busy2), 0);
      chk("mid_rst_rdv1", DW'(rdv1), 0);
      chk("mid_rst_rdv2", DW'(rdv2), 0);
      rd_(0); rd_(599); rd_(600); rd_(1000);
      idle(4);
      chk("drain1", DW'(h[0]), DW'(t));
      chk("drain2", DW'(h[1]), DW'(t));

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end
endmodule
